// File: rtl/mdpx_buffer_ctrl.sv
// mdpx_buffer_ctrl
//   Steers a Medipix byte stream into a two-bank (ping-pong) write buffer.
//   Each bank holds 2**BANK_W bytes. A bank is marked full when its last
//   offset is written, or when capture is stopped with a partial bank. The
//   reader frees a bank with a one-cycle In_Release pulse. Bytes that arrive
//   while the writer waits for a free bank are dropped and flagged.
//
//   Optional feature macro: MDPX_DROP_CNT_EN
//     defined   -> Out_Drop_Cnt is a saturating 16-bit dropped-byte counter,
//                  cleared on In_Start
//     undefined -> Out_Drop_Cnt is tied to zero
//
// Ports
//   In_Clk        clock, rising edge
//   In_Reset      asynchronous active-high reset
//   In_Start      pulse: arm capture (honoured in IDLE only)
//   In_Stop       pulse: end capture, flush partial bank
//   In_Valid      input byte strobe
//   In_Data       input byte
//   In_Release    per-bank reader-done pulse
//   Out_Data      buffer write data     (registered)
//   Out_Addr      buffer write address  {bank, offset} (registered)
//   Out_Wen       buffer write enable   (registered)
//   Out_Bank_Full per-bank full flags
//   Out_Last_Len  byte count of the most recently completed bank
//   Out_Busy      high whenever not IDLE
//   Out_Overflow  sticky dropped-byte flag, cleared on In_Start
//   Out_Drop_Cnt  dropped-byte count
module mdpx_buffer_ctrl #(
  parameter int BANK_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              In_Clk,
  input  logic              In_Reset,
  input  logic              In_Start,
  input  logic              In_Stop,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  input  logic [1:0]        In_Release,
  output logic [DATA_W-1:0] Out_Data,
  output logic [BANK_W:0]   Out_Addr,
  output logic              Out_Wen,
  output logic [1:0]        Out_Bank_Full,
  output logic [BANK_W:0]   Out_Last_Len,
  output logic              Out_Busy,
  output logic              Out_Overflow,
  output logic [15:0]       Out_Drop_Cnt
);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_FREE} state_t;

  localparam logic [BANK_W:0] BANK_SIZE = {1'b1, {BANK_W{1'b0}}};

  state_t              state_q, state_d;
  logic                bank_q, bank_d;
  logic [BANK_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]   data_d;
  logic [BANK_W:0]     addr_d;
  logic                wen_d;
  logic [1:0]          full_d, set_mask;
  logic [BANK_W:0]     last_d;
  logic                ovf_d;
  logic [BANK_W:0]     flush_len;

  // Length of the partial bank including a byte accepted in the stop cycle.
  assign flush_len = {1'b0, offset_q} + (BANK_W+1)'(In_Valid);

  always_ff @(posedge In_Clk or posedge In_Reset) begin
    if (In_Reset) begin
      state_q       <= IDLE;
      bank_q        <= 1'b0;
      offset_q      <= '0;
      Out_Wen       <= 1'b0;
      Out_Addr      <= '0;
      Out_Data      <= '0;
      Out_Bank_Full <= 2'b00;
      Out_Last_Len  <= '0;
      Out_Overflow  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      offset_q      <= offset_d;
      Out_Wen       <= wen_d;
      Out_Addr      <= addr_d;
      Out_Data      <= data_d;
      Out_Bank_Full <= full_d;
      Out_Last_Len  <= last_d;
      Out_Overflow  <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    offset_d = offset_q;
    wen_d    = 1'b0;
    addr_d   = Out_Addr;
    data_d   = Out_Data;
    last_d   = Out_Last_Len;
    ovf_d    = Out_Overflow;
    set_mask = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (In_Start) begin
          offset_d = '0;
          ovf_d    = 1'b0;
          state_d  = Out_Bank_Full[bank_q] ? WAIT_FREE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (In_Valid) begin
          wen_d    = 1'b1;
          addr_d   = {bank_q, offset_q};
          data_d   = In_Data;
          offset_d = offset_q + BANK_W'(1);
          if (offset_q == '1) begin
            set_mask[bank_q] = 1'b1;
            last_d           = BANK_SIZE;
            bank_d           = ~bank_q;
            state_d          = Out_Bank_Full[~bank_q] ? WAIT_FREE : CAPTURE;
          end
        end
        if (In_Stop) begin
          state_d = IDLE;
          // A stop coinciding with the final byte of a bank leaves nothing
          // to flush: that bank was already completed above.
          if (!(In_Valid && offset_q == '1) && flush_len != '0) begin
            set_mask[bank_q] = 1'b1;
            last_d           = flush_len;
            bank_d           = ~bank_q;
            offset_d         = '0;
          end
        end
      end
      WAIT_FREE: begin
        if (In_Valid) ovf_d = 1'b1;
        if (In_Stop) state_d = IDLE;
        else if (!Out_Bank_Full[bank_q]) state_d = CAPTURE;
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over a simultaneous release of the same bank.
    full_d = (Out_Bank_Full & ~In_Release) | set_mask;
  end

  assign Out_Busy = (state_q != IDLE);

`ifdef MDPX_DROP_CNT_EN
  logic        drop_inc, drop_clr;
  logic [15:0] drop_q;

  assign drop_clr = (state_q == IDLE) && In_Start;
  assign drop_inc = (state_q == WAIT_FREE) && In_Valid;

  always_ff @(posedge In_Clk or posedge In_Reset) begin
    if (In_Reset)                      drop_q <= '0;
    else if (drop_clr)                 drop_q <= '0;
    else if (drop_inc && drop_q != '1) drop_q <= drop_q + 16'd1;
  end

  assign Out_Drop_Cnt = drop_q;
`else
  assign Out_Drop_Cnt = '0;
`endif

endmodule

// File: tb/tb_mdpx_buffer_ctrl.sv
// Testbench for mdpx_buffer_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the buffer controller.
module tb_mdpx_buffer_ctrl;

  localparam int BANK_W = 9;
  localparam int DATA_W = 8;
  localparam int BANK   = 512;

  logic              In_Clk = 1'b0;
  logic              In_Reset = 1'b1;
  logic              In_Start = 1'b0;
  logic              In_Stop = 1'b0;
  logic              In_Valid = 1'b0;
  logic [DATA_W-1:0] In_Data = '0;
  logic [1:0]        In_Release = 2'b00;
  logic [DATA_W-1:0] Out_Data;
  logic [BANK_W:0]   Out_Addr;
  logic              Out_Wen;
  logic [1:0]        Out_Bank_Full;
  logic [BANK_W:0]   Out_Last_Len;
  logic              Out_Busy;
  logic              Out_Overflow;
  logic [15:0]       Out_Drop_Cnt;

  mdpx_buffer_ctrl #(.BANK_W(BANK_W), .DATA_W(DATA_W)) dut (
    .In_Clk        (In_Clk),
    .In_Reset      (In_Reset),
    .In_Start      (In_Start),
    .In_Stop       (In_Stop),
    .In_Valid      (In_Valid),
    .In_Data       (In_Data),
    .In_Release    (In_Release),
    .Out_Data      (Out_Data),
    .Out_Addr      (Out_Addr),
    .Out_Wen       (Out_Wen),
    .Out_Bank_Full (Out_Bank_Full),
    .Out_Last_Len  (Out_Last_Len),
    .Out_Busy      (Out_Busy),
    .Out_Overflow  (Out_Overflow),
    .Out_Drop_Cnt  (Out_Drop_Cnt)
  );

  always #5 In_Clk = ~In_Clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 = idle, 1 = capturing, 2 = waiting for a bank.
  int       m_mode, m_bank, m_off;
  bit       e_wen;
  int       e_addr, e_data, e_last, e_drop;
  bit [1:0] e_full;
  bit       e_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_bank = 0; m_off = 0;
    e_wen = 0; e_addr = 0; e_data = 0; e_last = 0; e_drop = 0;
    e_full = 2'b00; e_ovf = 0;
  endtask

  task automatic model_clk(input bit st, input bit sp, input bit v, input int d, input bit [1:0] rel);
    bit [1:0] old_full;
    bit [1:0] set;
    old_full = e_full;
    set = 2'b00;
    e_wen = 0;
    case (m_mode)
      0: if (st) begin
        m_off = 0; e_ovf = 0; e_drop = 0;
        m_mode = old_full[m_bank] ? 2 : 1;
      end
      1: begin
        if (v) begin
          e_wen = 1; e_addr = m_bank * BANK + m_off; e_data = d;
          m_off++;
          if (m_off == BANK) begin
            set[m_bank] = 1'b1; e_last = BANK;
            m_bank = 1 - m_bank; m_off = 0;
            m_mode = old_full[m_bank] ? 2 : 1;
          end
        end
        if (sp) begin
          if (m_off > 0) begin
            set[m_bank] = 1'b1; e_last = m_off;
            m_bank = 1 - m_bank; m_off = 0;
          end
          m_mode = 0;
        end
      end
      default: begin
        if (v) begin
          e_ovf = 1;
`ifdef MDPX_DROP_CNT_EN
          if (e_drop < 65535) e_drop++;
`endif
        end
        if (sp) m_mode = 0;
        else if (!old_full[m_bank]) m_mode = 1;
      end
    endcase
    e_full = (old_full & ~rel) | set;
  endtask

  task automatic compare_all();
    check_val("wen", Out_Wen, e_wen);
    if (e_wen) begin
      check_val("addr", Out_Addr, e_addr);
      check_val("data", Out_Data, e_data);
    end
    check_val("bank_full", Out_Bank_Full, e_full);
    check_val("last_len", Out_Last_Len, e_last);
    check_val("busy", Out_Busy, (m_mode != 0));
    check_val("overflow", Out_Overflow, e_ovf);
    check_val("drop_cnt", Out_Drop_Cnt, e_drop);
  endtask

  task automatic step(input bit st, input bit sp, input bit v, input int d, input bit [1:0] rel);
    In_Start = st; In_Stop = sp; In_Valid = v; In_Data = d[DATA_W-1:0]; In_Release = rel;
    @(posedge In_Clk);
    model_clk(st, sp, v, d & 8'hFF, rel);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    In_Reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge In_Clk);
    #1;
    compare_all();
    In_Reset = 1'b0;
  endtask

  int exp_drop10;

  initial begin
`ifdef MDPX_DROP_CNT_EN
    exp_drop10 = 10;
`else
    exp_drop10 = 0;
`endif
    model_reset();
    repeat (2) @(posedge In_Clk);
    #1;
    compare_all();
    In_Reset = 1'b0;
    idle(2);

    // Fill bank 0 with a repeating 0x00..0xFF ramp.
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < BANK; i++) step(0, 0, 1, i % 256, 2'b00);
    check_val("b0_full", Out_Bank_Full, 2'b01);
    check_val("b0_len", Out_Last_Len, 512);
    step(0, 0, 1, 8'hA5, 2'b00);
    check_val("b1_first_addr", Out_Addr, 512);

    // Fill bank 1 with no release, then overrun.
    for (int i = 1; i < BANK; i++) step(0, 0, 1, $urandom, 2'b00);
    check_val("both_full", Out_Bank_Full, 2'b11);
    for (int i = 0; i < 10; i++) step(0, 0, 1, $urandom, 2'b00);
    check_val("ovf_set", Out_Overflow, 1);
    check_val("drop10", Out_Drop_Cnt, exp_drop10);
    check_val("busy_wait", Out_Busy, 1);
    step(0, 0, 0, 0, 2'b01);
    idle(1);
    step(0, 0, 1, 8'h3C, 2'b00);
    check_val("resume_addr", Out_Addr, 0);
    check_val("resume_wen", Out_Wen, 1);
    step(0, 1, 0, 0, 2'b00);
    idle(2);

    // Partial bank flushed by stop, with a byte in the stop cycle.
    do_reset();
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 37; i++) step(0, 0, 1, $urandom, 2'b00);
    step(0, 1, 1, 8'h77, 2'b00);
    check_val("flush_full", Out_Bank_Full, 2'b01);
    check_val("flush_len", Out_Last_Len, 38);
    check_val("flush_busy", Out_Busy, 0);
    idle(2);

    // Bank 1 completes in the same cycle as its release pulse.
    step(0, 0, 0, 0, 2'b01);
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < BANK - 1; i++) step(0, 0, 1, $urandom, 2'b00);
    step(0, 0, 1, $urandom, 2'b10);
    check_val("set_wins", Out_Bank_Full[1], 1);
    step(0, 1, 0, 0, 2'b11);
    idle(2);

    // Reset in the middle of a capture.
    do_reset();
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 200; i++) step(0, 0, 1, $urandom, 2'b00);
    In_Valid = 1'b1;
    do_reset();
    check_val("rst_wen", Out_Wen, 0);
    check_val("rst_addr", Out_Addr, 0);
    idle(1);
    step(1, 0, 0, 0, 2'b00);
    step(0, 0, 1, 8'h11, 2'b00);
    check_val("post_rst_addr", Out_Addr, 0);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 2),
           ($urandom_range(0, 99) < 75), $urandom,
           {($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 1)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdpx_buffer_ctrl.md
MDPX_BUFFER_CTRL -- requirements
Module: mdpx_buffer_ctrl

Interface
REQ-001 SHALL have parameter BANK_W, default 9, giving log2 bytes per bank (512); buffer address width is BANK_W+1.
REQ-002 SHALL have parameter DATA_W, default 8, giving the data byte width.
REQ-003 SHALL have port In_Clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port In_Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port In_Start, input, 1: single-cycle pulse that arms capture.
REQ-006 SHALL have port In_Stop, input, 1: single-cycle pulse that ends capture and flushes the partial bank.
REQ-007 SHALL have port In_Valid, input, 1: Medipix byte strobe.
REQ-008 SHALL have port In_Data, input, DATA_W: Medipix byte.
REQ-009 SHALL have port In_Release, input, 2: per-bank reader-done pulse; bit n frees bank n.
REQ-010 SHALL have port Out_Data, output, DATA_W: buffer write data.
REQ-011 SHALL have port Out_Addr, output, BANK_W+1: buffer write address, {bank, offset}.
REQ-012 SHALL have port Out_Wen, output, 1: buffer write enable.
REQ-013 SHALL have port Out_Bank_Full, output, 2: per-bank full/ready-for-reader flags.
REQ-014 SHALL have port Out_Last_Len, output, BANK_W+1: byte count of the most recently completed bank (1..512).
REQ-015 SHALL have port Out_Busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port Out_Overflow, output, 1: sticky flag for bytes dropped.
REQ-017 SHALL have port Out_Drop_Cnt, output, 16: dropped-byte count (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, CAPTURE and WAIT_FREE.
REQ-019 IDLE SHALL ignore In_Valid; on In_Start it SHALL go to CAPTURE, or to WAIT_FREE if the current bank is full.
REQ-020 On In_Start the FSM SHALL clear the offset and Out_Overflow, keep the current bank, and leave the full flags unchanged.
REQ-021 In CAPTURE, each In_Valid SHALL drive Out_Wen=1, Out_Data=In_Data and Out_Addr={bank,offset} on the next cycle (latency 1, registered), then increment the offset.
REQ-022 Out_Wen SHALL be 0 in every cycle not caused by an accepted byte.
REQ-023 On the write at offset 511 the FSM SHALL:
- set Out_Bank_Full[bank];
- set Out_Last_Len=512;
- toggle the bank;
- clear the offset;
- go to WAIT_FREE if the new bank is full, else stay in CAPTURE.
REQ-024 In WAIT_FREE, In_Valid bytes SHALL be dropped (no write) and SHALL set Out_Overflow.
REQ-025 WAIT_FREE SHALL return to CAPTURE in the cycle after the current bank's full flag clears.
REQ-026 In_Release[n] SHALL clear Out_Bank_Full[n] on the next edge; a release of a bank that is not full SHALL be ignored.
REQ-027 If a full-set and a release hit the same bank in the same cycle, the set SHALL win.
REQ-028 On In_Stop in CAPTURE with offset>0, the FSM SHALL mark the bank full, set Out_Last_Len=offset, toggle the bank, clear the offset and go to IDLE.
REQ-029 On In_Stop in CAPTURE with offset=0, or in WAIT_FREE, the FSM SHALL go to IDLE with no flag change.
REQ-030 An In_Valid in the same cycle as In_Stop SHALL be accepted first and counted in the flush length.
REQ-031 In_Start SHALL be ignored outside IDLE; In_Stop SHALL be ignored in IDLE; if In_Start and In_Stop are high together in IDLE, Start SHALL win.
REQ-032 The offset SHALL wrap only through the bank toggle; no address outside {bank,0..511} SHALL ever be issued.

Reset
REQ-033 In_Reset SHALL asynchronously force:
- state to IDLE;
- bank, offset, Out_Wen, Out_Addr and Out_Data to 0;
- Out_Bank_Full to 2'b00;
- Out_Last_Len to 0;
- Out_Busy and Out_Overflow to 0;
- Out_Drop_Cnt to 0.
REQ-034 Reset mid-capture SHALL discard the partial bank with no flush and no spurious Out_Wen.

Configuration
REQ-035 Macro MDPX_DROP_CNT_EN, when defined, SHALL make Out_Drop_Cnt a 16-bit counter incremented per dropped byte, saturating at 0xFFFF and cleared on In_Start.
REQ-036 When MDPX_DROP_CNT_EN is undefined, Out_Drop_Cnt SHALL be tied to 0 with no counter logic; Out_Overflow SHALL behave identically in both cases.

Verification
REQ-037 Reset, In_Start, then 512 bytes 0x00..0xFF repeating: 512 writes to addresses 0..511 with 1-cycle latency, Out_Bank_Full=01, Out_Last_Len=512, next byte written to address 512.
REQ-038 Fill both banks with no release, then send 10 more bytes: state WAIT_FREE, no writes, Out_Overflow=1, Out_Drop_Cnt=10 (0 if the macro is undefined); In_Release=01 then resumes writes at address 0.
REQ-039 In_Start, 37 bytes, then In_Stop with In_Valid in the same cycle: 38 writes, Out_Bank_Full=01, Out_Last_Len=38, Out_Busy=0.
REQ-040 Bank 1 completes in the same cycle as In_Release=10: Out_Bank_Full[1]=1 (set wins).
REQ-041 In_Reset pulse at offset 200: Out_Wen stays 0 after reset, all outputs at their reset values, next In_Start writes to address 0.
